// File: rtl/l1_load_store_unit_if.sv
// l1_load_store_unit_if
// Bundles the core request/response handshake and the L1 data memory port
// of the load/store unit.
//   req_*  : core request (valid/ready, store flag, size, signedness, address, store data)
//   resp_* : one-cycle response pulse with extended load data and error flag
//   mem_*  : word-addressed memory port (combinational read, masked synchronous write, stall)
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (core request source plus memory)
interface l1_load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    logic                  mem_read_en;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [3:0]            mem_write_mask;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;
    logic                  mem_stall;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_read_en, mem_read_addr, mem_write_en, mem_write_addr,
        output mem_write_mask, mem_write_data,
        input  mem_read_data, mem_stall
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_read_en, mem_read_addr, mem_write_en, mem_write_addr,
        input  mem_write_mask, mem_write_data,
        output mem_read_data, mem_stall
    );
endinterface

// File: rtl/l1_load_store_unit.sv
// l1_load_store_unit
// Converts core byte/half/word loads and stores at any alignment into
// word-aligned memory accesses with byte write masks. Accesses that cross a
// word boundary are split into a low-word and a high-word access; load data
// from both words is merged, shifted down and sign/zero-extended.
// Ports:
//   clk     : single clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : request/response handshake and memory port (slave modport)
// Parameters:
//   ADDR_WIDTH    : byte address width
//   MISALIGNED_EN : 1 = split word-crossing accesses, 0 = reject them with resp_err
module l1_load_store_unit #(
    parameter int ADDR_WIDTH    = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input logic                  clk,
    input logic                  reset_n,
    l1_load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

    state_t                state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [1:0]            r_off;
    logic                  r_cross;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic [7:0]            r_mask8;
    logic [63:0]           r_shift;
    logic [31:0]           r_lo;

    // Request decode, only meaningful while IDLE
    logic [1:0]            req_off;
    logic [2:0]            req_bytes;
    logic [3:0]            req_size_mask;
    logic                  req_cross;
    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_word_addr;
    logic [7:0]            req_mask8;
    logic [63:0]           req_shift;
    logic [ADDR_WIDTH-1:0] hi_word_addr;

    always_comb begin
        req_off = bus.req_addr[1:0];
        case (bus.req_size)
            2'd0:    begin req_bytes = 3'd1; req_size_mask = 4'h1; end
            2'd1:    begin req_bytes = 3'd2; req_size_mask = 4'h3; end
            default: begin req_bytes = 3'd4; req_size_mask = 4'hF; end
        endcase
        req_cross     = ({1'b0, req_off} + req_bytes) > 3'd4;
        req_bad       = (bus.req_size == 2'd3) || (req_cross && !MISALIGNED_EN);
        req_word_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        req_mask8     = {4'h0, req_size_mask} << req_off;
        req_shift     = {32'h0, bus.req_wdata} << {req_off, 3'b000};
        // Wraps modulo 2^ADDR_WIDTH at the top of the address space
        hi_word_addr  = r_word_addr + ADDR_WIDTH'(4);
    end

    // Align the merged {hi,lo} words down to the access offset, then extend
    function automatic logic [31:0] extract(input logic [63:0] words,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        uns);
        logic [63:0] s;
        logic [31:0] r;
        s = words >> {off, 3'b000};
        case (size)
            2'd0:    r = uns ? {24'h0, s[7:0]}  : {{24{s[7]}},  s[7:0]};
            2'd1:    r = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = s[31:0];
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            bus.req_ready      <= 1'b1;
            bus.resp_valid     <= 1'b0;
            bus.resp_rdata     <= '0;
            bus.resp_err       <= 1'b0;
            bus.mem_read_en    <= 1'b0;
            bus.mem_read_addr  <= '0;
            bus.mem_write_en   <= 1'b0;
            bus.mem_write_addr <= '0;
            bus.mem_write_mask <= '0;
            bus.mem_write_data <= '0;
            r_we               <= 1'b0;
            r_size             <= '0;
            r_uns              <= 1'b0;
            r_off              <= '0;
            r_cross            <= 1'b0;
            r_word_addr        <= '0;
            r_mask8            <= '0;
            r_shift            <= '0;
            r_lo               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we          <= bus.req_we;
                        r_size        <= bus.req_size;
                        r_uns         <= bus.req_unsigned;
                        r_off         <= req_off;
                        r_cross       <= req_cross;
                        r_word_addr   <= req_word_addr;
                        r_mask8       <= req_mask8;
                        r_shift       <= req_shift;
                        bus.req_ready <= 1'b0;
                        if (req_bad) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state <= ACC_LO;
                            if (bus.req_we) begin
                                bus.mem_write_en   <= 1'b1;
                                bus.mem_write_addr <= req_word_addr;
                                bus.mem_write_mask <= req_mask8[3:0];
                                bus.mem_write_data <= req_shift[31:0];
                            end else begin
                                bus.mem_read_en   <= 1'b1;
                                bus.mem_read_addr <= req_word_addr;
                            end
                        end
                    end
                end

                ACC_LO: begin
                    if (!bus.mem_stall) begin
                        r_lo <= bus.mem_read_data;
                        if (r_cross) begin
                            // Strobes stay asserted; only address/lanes move to the next word
                            state <= ACC_HI;
                            if (r_we) begin
                                bus.mem_write_addr <= hi_word_addr;
                                bus.mem_write_mask <= r_mask8[7:4];
                                bus.mem_write_data <= r_shift[63:32];
                            end else begin
                                bus.mem_read_addr <= hi_word_addr;
                            end
                        end else begin
                            state              <= RESP;
                            bus.mem_read_en    <= 1'b0;
                            bus.mem_read_addr  <= '0;
                            bus.mem_write_en   <= 1'b0;
                            bus.mem_write_addr <= '0;
                            bus.mem_write_mask <= '0;
                            bus.mem_write_data <= '0;
                            bus.resp_valid     <= 1'b1;
                            bus.resp_err       <= 1'b0;
                            bus.resp_rdata     <= r_we ? 32'h0 :
                                extract({32'h0, bus.mem_read_data}, r_off, r_size, r_uns);
                        end
                    end
                end

                ACC_HI: begin
                    if (!bus.mem_stall) begin
                        state              <= RESP;
                        bus.mem_read_en    <= 1'b0;
                        bus.mem_read_addr  <= '0;
                        bus.mem_write_en   <= 1'b0;
                        bus.mem_write_addr <= '0;
                        bus.mem_write_mask <= '0;
                        bus.mem_write_data <= '0;
                        bus.resp_valid     <= 1'b1;
                        bus.resp_err       <= 1'b0;
                        bus.resp_rdata     <= r_we ? 32'h0 :
                            extract({bus.mem_read_data, r_lo}, r_off, r_size, r_uns);
                    end
                end

                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_load_store_unit.sv
// tb_l1_load_store_unit
// Directed test of l1_load_store_unit: one instance with misaligned splitting
// enabled backed by a small word memory model, and one with it disabled.
module tb_l1_load_store_unit;

    logic clk;
    logic reset_n;

    l1_load_store_unit_if #(.ADDR_WIDTH(32)) bus_a ();
    l1_load_store_unit_if #(.ADDR_WIDTH(32)) bus_b ();

    l1_load_store_unit #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    l1_load_store_unit #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64-word memory model indexed by address bits [7:2]
    logic [31:0] mem [0:63] = '{default: 32'h0};
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;
    wr_t         wlog[$];
    logic [31:0] rlog[$];
    int          both_cnt  = 0;
    int          resp_cnt_a = 0;
    int          strobe_cnt_b = 0;

    assign bus_a.mem_read_data = mem[bus_a.mem_read_addr[7:2]];
    assign bus_b.mem_read_data = 32'h0;
    assign bus_b.mem_stall     = 1'b0;

    always @(posedge clk) begin
        if (bus_a.mem_write_en && !bus_a.mem_stall) begin
            for (int b = 0; b < 4; b++)
                if (bus_a.mem_write_mask[b])
                    mem[bus_a.mem_write_addr[7:2]][b*8 +: 8] <= bus_a.mem_write_data[b*8 +: 8];
            wlog.push_back('{bus_a.mem_write_addr, bus_a.mem_write_mask, bus_a.mem_write_data});
        end
        if (bus_a.mem_read_en && !bus_a.mem_stall) rlog.push_back(bus_a.mem_read_addr);
        if (bus_a.mem_read_en && bus_a.mem_write_en) both_cnt++;
        if (bus_a.resp_valid) resp_cnt_a++;
        if (bus_b.mem_read_en || bus_b.mem_write_en) strobe_cnt_b++;
    end

    // Issue one request on instance a (sel=0) or b (sel=1); lat counts cycles
    // from the accepting cycle to the resp_valid cycle (-1 on timeout).
    task automatic do_req(input bit sel, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic pulse1);
        logic rv;
        @(negedge clk);
        if (!sel) begin
            bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_size = size;
            bus_a.req_unsigned = uns; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
        end else begin
            bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_size = size;
            bus_b.req_unsigned = uns; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
        end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        lat = -1; rdata = 32'hx; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            rv = sel ? bus_b.resp_valid : bus_a.resp_valid;
            if (rv) begin
                lat   = k;
                rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
                err   = sel ? bus_b.resp_err : bus_a.resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pulse1 = sel ? (!bus_b.resp_valid && bus_b.req_ready) : (!bus_a.resp_valid && bus_a.req_ready);
    endtask

    task automatic test_reset();
        n_chk++; if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus_a.req_ready); end
        n_chk++; if (bus_a.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus_a.resp_valid); end
        n_chk++; if (bus_a.resp_err !== 1'b0 || bus_a.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp: err %b rdata %h want 0/0", bus_a.resp_err, bus_a.resp_rdata); end
        n_chk++; if ({bus_a.mem_read_en, bus_a.mem_write_en, bus_a.mem_write_mask} !== 6'h0 ||
                     bus_a.mem_read_addr !== 32'h0 || bus_a.mem_write_addr !== 32'h0 || bus_a.mem_write_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem: re %b we %b mask %h ra %h wa %h wd %h want all 0", bus_a.mem_read_en,
                bus_a.mem_write_en, bus_a.mem_write_mask, bus_a.mem_read_addr, bus_a.mem_write_addr, bus_a.mem_write_data);
        end
    endtask

    task automatic test_word_aligned();
        int lat; logic [31:0] rd; logic er; logic p1; int w0;
        w0 = wlog.size();
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, p1);
        n_chk++; if (wlog.size() - w0 !== 1) begin n_fail++; $display("FAIL word_st_count: got %0d want 1", wlog.size() - w0); end
        else begin
            n_chk++; if (wlog[w0].addr !== 32'h10 || wlog[w0].mask !== 4'hF || wlog[w0].data !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL word_st_write: got %h/%h/%h want 00000010/f/deadbeef", wlog[w0].addr, wlog[w0].mask, wlog[w0].data); end
        end
        n_chk++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || p1 !== 1'b1) begin
            n_fail++; $display("FAIL word_st_resp: lat %0d err %b rdata %h pulse %b want 2/0/0/1", lat, er, rd, p1); end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || p1 !== 1'b1) begin
            n_fail++; $display("FAIL word_ld: lat %0d rdata %h err %b pulse %b want 2/deadbeef/0/1", lat, rd, er, p1); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic er; logic p1; int w0;
        w0 = wlog.size();
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, lat, rd, er, p1);
        n_chk++; if (wlog.size() - w0 !== 1) begin n_fail++; $display("FAIL byte_st_count: got %0d want 1", wlog.size() - w0); end
        else begin
            n_chk++; if (wlog[w0].addr !== 32'h10 || wlog[w0].mask !== 4'h8 || wlog[w0].data[31:24] !== 8'hA5) begin
                n_fail++; $display("FAIL byte_st_write: got %h/%h/%h want 00000010/8/a5xxxxxx", wlog[w0].addr, wlog[w0].mask, wlog[w0].data); end
        end
        do_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat !== 2 || rd !== 32'hFFFFFFA5 || er !== 1'b0) begin
            n_fail++; $display("FAIL byte_ld_signed: lat %0d rdata %h err %b want 2/ffffffa5/0", lat, rd, er); end
        do_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat !== 2 || rd !== 32'h000000A5 || er !== 1'b0) begin
            n_fail++; $display("FAIL byte_ld_unsigned: lat %0d rdata %h err %b want 2/000000a5/0", lat, rd, er); end
        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat !== 2 || rd !== 32'hFFFFA5AD) begin
            n_fail++; $display("FAIL half_ld_signed: lat %0d rdata %h want 2/ffffa5ad", lat, rd); end
    endtask

    task automatic test_cross_word();
        int lat; logic [31:0] rd; logic er; logic p1; int w0;
        w0 = wlog.size();
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h06, 32'h11223344, lat, rd, er, p1);
        n_chk++; if (wlog.size() - w0 !== 2) begin n_fail++; $display("FAIL cross_st_count: got %0d want 2", wlog.size() - w0); end
        else begin
            n_chk++; if (wlog[w0].addr !== 32'h4 || wlog[w0].mask !== 4'hC || wlog[w0].data[31:16] !== 16'h3344) begin
                n_fail++; $display("FAIL cross_st_lo: got %h/%h/%h want 00000004/c/3344xxxx", wlog[w0].addr, wlog[w0].mask, wlog[w0].data); end
            n_chk++; if (wlog[w0+1].addr !== 32'h8 || wlog[w0+1].mask !== 4'h3 || wlog[w0+1].data[15:0] !== 16'h1122) begin
                n_fail++; $display("FAIL cross_st_hi: got %h/%h/%h want 00000008/3/xxxx1122", wlog[w0+1].addr, wlog[w0+1].mask, wlog[w0+1].data); end
        end
        n_chk++; if (lat !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL cross_st_resp: lat %0d err %b want 3/0", lat, er); end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat !== 3 || rd !== 32'h11223344 || er !== 1'b0 || p1 !== 1'b1) begin
            n_fail++; $display("FAIL cross_ld: lat %0d rdata %h err %b pulse %b want 3/11223344/0/1", lat, rd, er, p1); end
    endtask

    task automatic test_stall();
        int lat; logic ok;
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_size = 2'd2;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = 32'h10; bus_a.req_wdata = 32'h0;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        bus_a.mem_stall = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (bus_a.mem_read_en !== 1'b1 || bus_a.mem_read_addr !== 32'h10 || bus_a.mem_write_en !== 1'b0 ||
                bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b0) ok = 1'b0;
            if (k < 2) @(negedge clk);
        end
        @(negedge clk);
        n_chk++; if (ok !== 1'b1 || bus_a.mem_read_en !== 1'b1 || bus_a.mem_read_addr !== 32'h10) begin
            n_fail++; $display("FAIL stall_hold: stable %b re %b ra %h want 1/1/00000010", ok, bus_a.mem_read_en, bus_a.mem_read_addr); end
        bus_a.mem_stall = 1'b0;
        lat = -1;
        for (int k = 4; k <= 20; k++) begin
            if (bus_a.resp_valid) begin lat = k; break; end
            @(negedge clk);
        end
        n_chk++; if (lat !== 5 || bus_a.resp_rdata !== 32'hA5ADBEEF) begin
            n_fail++; $display("FAIL stall_resp: lat %0d rdata %h want 5/a5adbeef", lat, bus_a.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic er; logic p1; int r0;
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h000000AB, lat, rd, er, p1);
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h00000000, 32'h000000CD, lat, rd, er, p1);
        r0 = rlog.size();
        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er, p1);
        n_chk++; if (rlog.size() - r0 !== 2) begin n_fail++; $display("FAIL wrap_read_count: got %0d want 2", rlog.size() - r0); end
        else begin
            n_chk++; if (rlog[r0] !== 32'hFFFFFFFC || rlog[r0+1] !== 32'h0) begin
                n_fail++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", rlog[r0], rlog[r0+1]); end
        end
        n_chk++; if (lat !== 3 || rd !== 32'hFFFFCDAB || er !== 1'b0) begin
            n_fail++; $display("FAIL wrap_ld: lat %0d rdata %h err %b want 3/ffffcdab/0", lat, rd, er); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; logic p1; int w0; int s0;
        w0 = wlog.size();
        do_req(1'b0, 1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, lat, rd, er, p1);
        n_chk++; if (lat < 1 || lat > 2 || er !== 1'b1 || rd !== 32'h0 || p1 !== 1'b1 || wlog.size() !== w0) begin
            n_fail++; $display("FAIL size3_a: lat %0d err %b rdata %h pulse %b writes %0d want 1..2/1/0/1/0",
                lat, er, rd, p1, wlog.size() - w0); end
        s0 = strobe_cnt_b;
        do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat < 1 || lat > 2 || er !== 1'b1 || rd !== 32'h0 || p1 !== 1'b1) begin
            n_fail++; $display("FAIL reject_cross: lat %0d err %b rdata %h pulse %b want 1..2/1/0/1", lat, er, rd, p1); end
        do_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat < 1 || lat > 2 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL size3_b: lat %0d err %b rdata %h want 1..2/1/0", lat, er, rd); end
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, rd, er, p1);
        n_chk++; if (lat !== 2 || er !== 1'b0 || strobe_cnt_b - s0 !== 1) begin
            n_fail++; $display("FAIL noreject_aligned: lat %0d err %b strobes %0d want 2/0/1", lat, er, strobe_cnt_b - s0); end
    endtask

    task automatic test_reset_mid();
        int w0; int c0; logic hi_seen;
        w0 = wlog.size();
        c0 = resp_cnt_a;
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_size = 2'd2;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = 32'h06; bus_a.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        n_chk++; if (bus_a.mem_write_en !== 1'b1 || bus_a.mem_write_addr !== 32'h4) begin
            n_fail++; $display("FAIL rstmid_acc_lo: we %b wa %h want 1/00000004", bus_a.mem_write_en, bus_a.mem_write_addr); end
        reset_n = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_a.req_ready !== 1'b1 || bus_a.mem_write_en !== 1'b0 || bus_a.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: ready %b we %b rv %b want 1/0/0", bus_a.req_ready, bus_a.mem_write_en, bus_a.resp_valid); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        hi_seen = 1'b0;
        for (int i = w0; i < wlog.size(); i++) if (wlog[i].addr == 32'h8) hi_seen = 1'b1;
        n_chk++; if (hi_seen !== 1'b0 || resp_cnt_a - c0 !== 0) begin
            n_fail++; $display("FAIL rstmid_after: hi_write %b resp_pulses %0d want 0/0", hi_seen, resp_cnt_a - c0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = 2'd0;
        bus_a.req_unsigned = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.mem_stall = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = 2'd0;
        bus_b.req_unsigned = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_word_aligned();
        test_byte();
        test_cross_word();
        test_stall();
        test_wrap();
        test_errors();
        test_reset_mid();
        n_chk++; if (both_cnt !== 0) begin n_fail++; $display("FAIL both_strobes: got %0d want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
